// File: rtl/csa_bist_ctrl.sv
// csa_bist_ctrl: built-in self-test controller for an 8-bit carry-select adder.
// It drives LFSR operands to the adder, checks the sum and carry-out against
// A+B one cycle later, counts mismatches (saturating) and reports pass/fail.
// Optional feature macro: CSA_BIST_MISR_EN adds a 9-bit MISR of the captured
// responses on 'signature'; without it 'signature' is tied to zero.
`timescale 1ns/1ps

module csa_bist_ctrl #(
  parameter int unsigned N_PATTERNS = 256,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [7:0] A_o,
  output logic [7:0] B_o,
  output logic       Cin0_o,
  output logic       Cin1_o,
  input  logic [7:0] S_i,
  input  logic       Cout_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [8:0] signature
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1 at run start.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LAST_PAT = 16'(N_PATTERNS - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [15:0] pat_cnt;
  logic        cap_valid;
  logic [8:0]  cap_resp;
  logic [8:0]  cap_exp;
  logic [8:0]  exp_sum;
  logic        accept;
  logic        cmp_en;
  logic        mismatch;
  logic [7:0]  err_next;

  assign Cin0_o = 1'b0;
  assign Cin1_o = 1'b1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; abort wins in RUN/DRAIN and also blocks a start in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !abort) state_next = RUN;
      RUN:     if (abort) state_next = IDLE;
               else if (pat_cnt == LAST_PAT) state_next = DRAIN;
      DRAIN:   state_next = abort ? IDLE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs and operand drive; operands are zero outside RUN.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
    A_o  = 8'h00;
    B_o  = 8'h00;
    if (state == RUN) begin
      A_o = lfsr[7:0];
      B_o = lfsr[15:8];
    end
  end

  // Pattern generator step, reference sum and compare of last cycle's capture.
  always_comb begin
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    exp_sum   = {1'b0, A_o} + {1'b0, B_o};
    accept    = (state == IDLE) && start && !abort;
    cmp_en    = cap_valid && !abort && ((state == RUN) || (state == DRAIN));
    mismatch  = cmp_en && (cap_resp != cap_exp);
    err_next  = err_cnt;
    if (mismatch && (err_cnt != 8'hFF)) err_next = err_cnt + 8'd1;
  end

  // Run datapath: LFSR, pattern counter, response capture, error count, pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= SEED;
      pat_cnt   <= 16'h0000;
      cap_valid <= 1'b0;
      cap_resp  <= 9'h000;
      cap_exp   <= 9'h000;
      err_cnt   <= 8'h00;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lfsr      <= SEED_EFF;
            pat_cnt   <= 16'h0000;
            cap_valid <= 1'b0;
            err_cnt   <= 8'h00;
            pass      <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            cap_valid <= 1'b0;
            pass      <= 1'b0;
          end else begin
            lfsr      <= lfsr_next;
            pat_cnt   <= pat_cnt + 16'd1;
            cap_resp  <= {Cout_i, S_i};
            cap_exp   <= exp_sum;
            cap_valid <= 1'b1;
            err_cnt   <= err_next;
          end
        end
        DRAIN: begin
          cap_valid <= 1'b0;
          if (abort) begin
            pass <= 1'b0;
          end else begin
            err_cnt <= err_next;
            pass    <= (err_next == 8'h00);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CSA_BIST_MISR_EN
  logic [8:0] misr;
  logic [8:0] misr_next;

  // MISR step for x^9+x^5+1, folding in the response being compared.
  always_comb begin
    misr_next = {misr[7:0], 1'b0} ^ (misr[8] ? 9'h021 : 9'h000) ^ cap_resp;
  end

  // MISR register: cleared on an accepted start, advanced on every compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      misr <= 9'h000;
    else if (accept) misr <= 9'h000;
    else if (cmp_en) misr <= misr_next;
  end

  assign signature = misr;
`else
  assign signature = 9'h000;
`endif

endmodule
